// File: rtl/mtm_alu_cmd_ctrl_if.sv
// Byte-stream input, ALU-core handshake and response-stream bundle of the ALU command controller.
interface mtm_alu_cmd_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_is_ctl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [31:0] alu_c;
    logic [7:0]  alu_ctl;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;

    modport master (
        input  in_valid, in_data, in_is_ctl, alu_done, alu_c, alu_ctl, out_ready,
        output in_ready, alu_a, alu_b, alu_op, alu_start, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, in_is_ctl, alu_done, alu_c, alu_ctl, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, alu_start, out_valid, out_data
    );
endinterface

// File: rtl/mtm_alu_cmd_ctrl.sv
// Command sequencer: collects operands and control byte, validates CRC4/opcode,
// runs the ALU core through a start/done handshake and streams the response or an error byte.
module mtm_alu_cmd_ctrl #(
    parameter int IDLE_TIMEOUT = 1024,
    parameter int TO_W         = 10
) (
    input  logic               clk,
    input  logic               rst,
    mtm_alu_cmd_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_COLLECT   = 4'd1,
        S_CHECK     = 4'd2,
        S_ISSUE     = 4'd3,
        S_WAIT_ALU  = 4'd4,
        S_SEND_DATA = 4'd5,
        S_SEND_CTL  = 4'd6,
        S_SEND_ERR  = 4'd7,
        S_DRAIN     = 4'd8
    } state_t;

    // Error flags are {data, crc, op}; the error byte repeats them twice.
    localparam logic [2:0] ERR_DATA = 3'b100;
    localparam logic [2:0] ERR_CRC  = 3'b010;
    localparam logic [2:0] ERR_OP   = 3'b001;

    function automatic logic [3:0] crc4_calc(input logic [67:0] msg);
        logic [3:0] crc;
        logic       fb;
        crc = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb  = crc[3] ^ msg[i];
            crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return crc;
    endfunction

    function automatic logic [7:0] err_byte(input logic [2:0] flags);
        return {1'b1, flags, flags, ^{1'b1, flags, flags}};
    endfunction

    function automatic logic op_valid(input logic [2:0] op);
        logic ok;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b101: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t          state_r, next_state_s;
    logic [3:0]      byte_cnt_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [63:0]     ba_r;
    logic [2:0]      op_r;
    logic [3:0]      crc_rx_r;
    logic            drain_r;
    logic [31:0]     resp_r;
    logic [1:0]      out_cnt_r;
    logic [31:0]     alu_a_r, alu_b_r;
    logic [2:0]      alu_op_r;
    logic            in_ready_r, alu_start_r, out_valid_r;
    logic [7:0]      out_data_r;
    logic            in_ready_nx_s, alu_start_nx_s, out_valid_nx_s;
    logic [7:0]      out_data_nx_s;
    logic            in_acc_s, out_acc_s, timeout_s, shift_s, ctl_latch_s, crc_ok_s, op_ok_s;
    logic [2:0]      err_sel_s;

    // in_ready_r is high exactly in COLLECT and DRAIN, so it doubles as the accept window.
    assign in_acc_s    = bus.in_valid & in_ready_r;
    assign out_acc_s   = out_valid_r & bus.out_ready;
    assign timeout_s   = in_ready_r & ~in_acc_s & (byte_cnt_r != 4'd0) &
                         (to_cnt_r == TO_W'(IDLE_TIMEOUT - 1));
    assign shift_s     = (state_r == S_COLLECT) & in_acc_s & ~bus.in_is_ctl & (byte_cnt_r != 4'd8);
    assign ctl_latch_s = (state_r == S_COLLECT) & in_acc_s & bus.in_is_ctl & (byte_cnt_r == 4'd8);
    assign crc_ok_s    = (crc4_calc({ba_r, 1'b1, op_r}) == crc_rx_r);
    assign op_ok_s     = op_valid(op_r);
    assign err_sel_s   = (state_r == S_CHECK) ? (crc_ok_s ? ERR_OP : ERR_CRC) : ERR_DATA;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE:      next_state_s = S_COLLECT;
            S_COLLECT: begin
                if (in_acc_s && bus.in_is_ctl) begin
                    next_state_s = (byte_cnt_r == 4'd8) ? S_CHECK : S_SEND_ERR;
                end else if (in_acc_s && (byte_cnt_r == 4'd8)) begin
                    next_state_s = S_SEND_ERR;
                end else begin
                    next_state_s = S_COLLECT;
                end
            end
            S_CHECK:     next_state_s = (crc_ok_s && op_ok_s) ? S_ISSUE : S_SEND_ERR;
            S_ISSUE:     next_state_s = S_WAIT_ALU;
            S_WAIT_ALU:  next_state_s = bus.alu_done ? S_SEND_DATA : S_WAIT_ALU;
            S_SEND_DATA: next_state_s = (out_acc_s && (out_cnt_r == 2'd3)) ? S_SEND_CTL : S_SEND_DATA;
            S_SEND_CTL:  next_state_s = out_acc_s ? S_IDLE : S_SEND_CTL;
            S_SEND_ERR: begin
                if (out_acc_s) begin
                    next_state_s = drain_r ? S_DRAIN : S_IDLE;
                end else begin
                    next_state_s = S_SEND_ERR;
                end
            end
            S_DRAIN:     next_state_s = ((in_acc_s && bus.in_is_ctl) || timeout_s) ? S_IDLE : S_DRAIN;
            default:     next_state_s = S_IDLE;
        endcase
    end

    // Next values of the registered handshake outputs.
    always_comb begin
        in_ready_nx_s  = (next_state_s == S_COLLECT) || (next_state_s == S_DRAIN);
        alu_start_nx_s = (next_state_s == S_ISSUE);
        out_valid_nx_s = out_valid_r;
        out_data_nx_s  = out_data_r;
        if ((next_state_s == S_SEND_ERR) && (state_r != S_SEND_ERR)) begin
            out_valid_nx_s = 1'b1;
            out_data_nx_s  = err_byte(err_sel_s);
        end else if ((state_r == S_WAIT_ALU) && bus.alu_done) begin
            out_valid_nx_s = 1'b1;
            out_data_nx_s  = bus.alu_c[31:24];
        end else if ((state_r == S_SEND_DATA) && out_acc_s) begin
            out_data_nx_s  = resp_r[31:24];
        end else if (((state_r == S_SEND_CTL) || (state_r == S_SEND_ERR)) && out_acc_s) begin
            out_valid_nx_s = 1'b0;
        end else begin
            out_valid_nx_s = out_valid_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            alu_start_r <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
        end else begin
            in_ready_r  <= in_ready_nx_s;
            alu_start_r <= alu_start_nx_s;
            out_valid_r <= out_valid_nx_s;
            out_data_r  <= out_data_nx_s;
        end
    end

    // Command capture, inter-byte timeout, ALU operands and response shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_r <= 4'd0;
            to_cnt_r   <= {TO_W{1'b0}};
            ba_r       <= 64'd0;
            op_r       <= 3'd0;
            crc_rx_r   <= 4'd0;
            drain_r    <= 1'b0;
            resp_r     <= 32'd0;
            out_cnt_r  <= 2'd0;
            alu_a_r    <= 32'd0;
            alu_b_r    <= 32'd0;
            alu_op_r   <= 3'd0;
        end else begin
            if (state_r == S_IDLE || timeout_s) begin
                byte_cnt_r <= 4'd0;
            end else if (shift_s) begin
                ba_r       <= {ba_r[55:0], bus.in_data};
                byte_cnt_r <= byte_cnt_r + 4'd1;
            end
            // The idle counter only runs while a partial command is held.
            if (in_acc_s || !in_ready_r || (byte_cnt_r == 4'd0) || timeout_s) begin
                to_cnt_r <= {TO_W{1'b0}};
            end else begin
                to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
            end
            if (ctl_latch_s) begin
                op_r     <= bus.in_data[6:4];
                crc_rx_r <= bus.in_data[3:0];
            end
            if ((state_r == S_COLLECT) && (next_state_s == S_SEND_ERR)) begin
                drain_r <= ~bus.in_is_ctl;
            end else if (state_r == S_CHECK) begin
                drain_r <= 1'b0;
            end
            if (next_state_s == S_ISSUE) begin
                alu_a_r  <= ba_r[31:0];
                alu_b_r  <= ba_r[63:32];
                alu_op_r <= op_r;
            end
            if ((state_r == S_WAIT_ALU) && bus.alu_done) begin
                resp_r    <= {bus.alu_c[23:0], bus.alu_ctl};
                out_cnt_r <= 2'd0;
            end else if ((state_r == S_SEND_DATA) && out_acc_s) begin
                resp_r    <= {resp_r[23:0], 8'h00};
                out_cnt_r <= out_cnt_r + 2'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.alu_start = alu_start_r;
    assign bus.alu_a     = alu_a_r;
    assign bus.alu_b     = alu_b_r;
    assign bus.alu_op    = alu_op_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
endmodule
